// File: rtl/nn_pkg.sv
// Shared types and helpers for the NN result collector.
// fp_key maps fp32 bit patterns onto an unsigned total order.
package nn_pkg;

   localparam int FP_W      = 32;
   localparam int FRAME_LEN = 16;

   typedef enum logic {
      WR_FILL,
      WR_DROP
   } wr_state_e;

   function automatic logic [FP_W-1:0] fp_key(input logic [FP_W-1:0] x);
      return x[FP_W-1] ? ~x : (x ^ {1'b1, {(FP_W-1){1'b0}}});
   endfunction

endpackage

// File: rtl/fp32_max.sv
// Combinational fp32 maximum under the fp_key ordering.
// Ties keep input a.
module fp32_max
   import nn_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] y
);

   assign y = (fp_key(b) > fp_key(a)) ? b : a;

endmodule

// File: rtl/nn_out_collector.sv
// Ping-pong frame collector for the NN result stream.
// Serves completed frames with last marker and frame maximum.
module nn_out_collector #(
   parameter int DATA_W    = nn_pkg::FP_W,
   parameter int FRAME_LEN = nn_pkg::FRAME_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [DATA_W-1:0] out_max,
   output logic              overflow,
   output logic              busy
);
   import nn_pkg::*;

   localparam int            CW   = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   wr_state_e state_q, state_d;
   logic      wr_bank_q, wr_bank_d;
   logic      rd_bank_q, rd_bank_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [1:0]    full_q, full_d;
   logic          overflow_q, overflow_d;
   logic [1:0][DATA_W-1:0] max_q, max_d;
   logic [1:0][FRAME_LEN-1:0][DATA_W-1:0] bank_q, bank_d;
   logic [DATA_W-1:0] run_max;
   logic              rd_fire;

   fp32_max u_max (
      .a (max_q[wr_bank_q]),
      .b (in_data),
      .y (run_max)
   );

   always_comb begin
      state_d    = state_q;
      wr_bank_d  = wr_bank_q;
      wr_cnt_d   = wr_cnt_q;
      rd_bank_d  = rd_bank_q;
      rd_cnt_d   = rd_cnt_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      max_d      = max_q;
      bank_d     = bank_q;
      rd_fire    = full_q[rd_bank_q] & out_ready;

      if (rd_fire) begin
         if (rd_cnt_q == LAST) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
         end
      end

      // Set-full targets wr_bank, never the bank being cleared this cycle.
      if (in_valid) begin
         unique case (state_q)
            WR_FILL: begin
               if (wr_cnt_q == '0 && full_q[wr_bank_q]) begin
                  state_d    = WR_DROP;
                  overflow_d = 1'b1;
                  wr_cnt_d   = CW'(1);
               end else begin
                  bank_d[wr_bank_q][wr_cnt_q] = in_data;
                  max_d[wr_bank_q] = (wr_cnt_q == '0) ? in_data : run_max;
                  if (wr_cnt_q == LAST) begin
                     full_d[wr_bank_q] = 1'b1;
                     wr_bank_d         = ~wr_bank_q;
                     wr_cnt_d          = '0;
                  end else begin
                     wr_cnt_d = wr_cnt_q + CW'(1);
                  end
               end
            end
            WR_DROP: begin
               if (wr_cnt_q == LAST) begin
                  state_d  = WR_FILL;
                  wr_cnt_d = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + CW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WR_FILL;
         wr_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         rd_bank_q  <= 1'b0;
         rd_cnt_q   <= '0;
         full_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_bank_q  <= rd_bank_d;
         rd_cnt_q   <= rd_cnt_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      max_q  <= max_d;
      bank_q <= bank_d;
   end

   assign out_valid = full_q[rd_bank_q];
   assign out_data  = out_valid ? bank_q[rd_bank_q][rd_cnt_q] : '0;
   assign out_last  = out_valid & (rd_cnt_q == LAST);
   assign out_max   = out_valid ? max_q[rd_bank_q] : '0;
   assign overflow  = overflow_q;
   assign busy      = (|full_q) | (wr_cnt_q != '0);

endmodule
